// File: rtl/painter_modes_if.sv
// Pixel request / colour response bundle between the scan logic and painter_modes.
// The scan side drives the master modport; the painter sits on the slave modport.
interface painter_modes_if #(
  parameter int COORD_BITS = 6,
  parameter int FRAME_BITS = 10,
  parameter int CHAN_BITS  = 8
);
  logic [FRAME_BITS-1:0]  frame;
  logic [7:0]             subframe;
  logic [COORD_BITS-1:0]  x;
  logic [COORD_BITS-1:0]  y;
  logic                   req;
  logic [1:0]             mode_sel;
  logic                   mode_load;
  logic [3*CHAN_BITS-1:0] rgb;
  logic                   rgb_valid;
  logic [1:0]             cur_mode;

  modport master (
    output frame, subframe, x, y, req, mode_sel, mode_load,
    input  rgb, rgb_valid, cur_mode
  );

  modport slave (
    input  frame, subframe, x, y, req, mode_sel, mode_load,
    output rgb, rgb_valid, cur_mode
  );
endinterface

// File: rtl/painter_modes.sv
// Two-stage, four-pattern RGB source with frame-aligned mode switching and optional auto-cycling.
// Define PAINTER_DIAG_EN to add a moving diagonal marker on the blue channel in modes 0-2.
module painter_modes #(
  parameter int COORD_BITS  = 6,
  parameter int FRAME_BITS  = 10,
  parameter int CHAN_BITS   = 8,
  parameter int INIT_MODE   = 0,
  parameter int AUTO_FRAMES = 0
) (
  input  logic           clk,
  input  logic           reset,
  painter_modes_if.slave bus
);

  localparam int XW       = COORD_BITS + 2;
  localparam int FS       = (XW > 8) ? XW : 8;
  localparam int CNT_BITS = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_BITS-1:0] AUTO_LAST =
    (AUTO_FRAMES > 0) ? CNT_BITS'(AUTO_FRAMES - 1) : '0;

  // ---------------- mode control ----------------
  logic [FRAME_BITS-1:0] frame_q_reg;
  logic [1:0]            cur_mode_reg, cur_mode_next;
  logic                  pend_flag_reg, pend_flag_next;
  logic [1:0]            pend_mode_reg, pend_mode_next;
  logic [CNT_BITS-1:0]   auto_cnt_reg, auto_cnt_next;
  logic                  fc;

  assign fc = (bus.frame != frame_q_reg);

  always_comb begin
    cur_mode_next  = cur_mode_reg;
    pend_flag_next = pend_flag_reg;
    pend_mode_next = pend_mode_reg;
    auto_cnt_next  = auto_cnt_reg;
    if (fc) begin
      if (pend_flag_reg) begin
        cur_mode_next  = pend_mode_reg;
        pend_flag_next = 1'b0;
        auto_cnt_next  = '0;
      end else if (AUTO_FRAMES > 0) begin
        if (auto_cnt_reg == AUTO_LAST) begin
          cur_mode_next = cur_mode_reg + 2'd1;
          auto_cnt_next = '0;
        end else begin
          auto_cnt_next = auto_cnt_reg + CNT_BITS'(1);
        end
      end
    end
    // A load coinciding with a frame change applies the old pending value above
    // and leaves the new request pending for the following change.
    if (bus.mode_load) begin
      pend_mode_next = bus.mode_sel;
      pend_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q_reg   <= '0;
      cur_mode_reg  <= 2'(INIT_MODE);
      pend_flag_reg <= 1'b0;
      pend_mode_reg <= 2'd0;
      auto_cnt_reg  <= '0;
    end else begin
      frame_q_reg   <= bus.frame;
      cur_mode_reg  <= cur_mode_next;
      pend_flag_reg <= pend_flag_next;
      pend_mode_reg <= pend_mode_next;
      auto_cnt_reg  <= auto_cnt_next;
    end
  end

  // ---------------- stage 1: capture request ----------------
  logic                  valid_s1_reg;
  logic [COORD_BITS-1:0] x_s1_reg, y_s1_reg;
  logic [FS-1:0]         frame_s1_reg;
  logic [7:0]            sub_s1_reg;
  logic [1:0]            mode_s1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1_reg <= 1'b0;
      x_s1_reg     <= '0;
      y_s1_reg     <= '0;
      frame_s1_reg <= '0;
      sub_s1_reg   <= '0;
      mode_s1_reg  <= 2'd0;
    end else begin
      valid_s1_reg <= bus.req;
      if (bus.req) begin
        x_s1_reg     <= bus.x;
        y_s1_reg     <= bus.y;
        frame_s1_reg <= bus.frame[FS-1:0];
        sub_s1_reg   <= bus.subframe;
        mode_s1_reg  <= cur_mode_reg;
      end
    end
  end

  // ---------------- pattern math ----------------
  // The tile pattern only looks at bits [6:0] of the wrapped sums.
  logic [6:0] xx, yy;
  logic       blank;

  assign xx    = 7'({2'b00, x_s1_reg} + frame_s1_reg[XW-1:0]);
  assign yy    = 7'({2'b00, y_s1_reg} + {2'b00, frame_s1_reg[XW-1:2]});
  assign blank = ~(xx[3] & yy[3]);

  logic [CHAN_BITS-1:0] rep_x, rep_y;
  logic [CHAN_BITS-1:0] red_grad, grn_grad, blu_grad, sub_just;

  // rep(): 3-bit value repeated MSB-first; grad/sub: MSB-justified fields.
  for (genvar gi = 0; gi < CHAN_BITS; gi++) begin : g_bit
    localparam int J = CHAN_BITS - 1 - gi;
    assign rep_x[gi] = xx[2 - (J % 3)];
    assign rep_y[gi] = yy[2 - (J % 3)];
    if (COORD_BITS - CHAN_BITS + gi >= 0) begin : g_coord
      assign red_grad[gi] = x_s1_reg[COORD_BITS - CHAN_BITS + gi];
      assign grn_grad[gi] = y_s1_reg[COORD_BITS - CHAN_BITS + gi];
    end else begin : g_coord_pad
      assign red_grad[gi] = 1'b0;
      assign grn_grad[gi] = 1'b0;
    end
    if (8 - CHAN_BITS + gi >= 0) begin : g_byte
      assign blu_grad[gi] = frame_s1_reg[8 - CHAN_BITS + gi];
      assign sub_just[gi] = sub_s1_reg[8 - CHAN_BITS + gi];
    end else begin : g_byte_pad
      assign blu_grad[gi] = 1'b0;
      assign sub_just[gi] = 1'b0;
    end
  end

  logic [CHAN_BITS-1:0] tile [3];
  logic [CHAN_BITS-1:0] bars [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign tile[gi] = blank ? '0 :
                      ((yy[4 + gi] ? rep_y : '0) | (xx[4 + gi] ? rep_x : '0));
    assign bars[gi] = {CHAN_BITS{x_s1_reg[COORD_BITS - 3 + gi]}};
  end

`ifdef PAINTER_DIAG_EN
  logic diag_hit;
  assign diag_hit = ((x_s1_reg ^ frame_s1_reg[XW-1:2]) == y_s1_reg);
`endif

  logic [CHAN_BITS-1:0]   red_n, grn_n, blu_n;
  logic [3*CHAN_BITS-1:0] rgb_next;

  always_comb begin
    red_n = '0;
    grn_n = '0;
    blu_n = '0;
    unique case (mode_s1_reg)
      2'd0: begin
        red_n = tile[0];
        grn_n = tile[1];
        blu_n = tile[2];
      end
      2'd1: begin
        red_n = bars[0];
        grn_n = bars[1];
        blu_n = bars[2];
      end
      2'd2: begin
        red_n = red_grad;
        grn_n = grn_grad;
        blu_n = blu_grad;
      end
      default: begin
        red_n = sub_just;
        grn_n = sub_just;
        blu_n = sub_just;
      end
    endcase
`ifdef PAINTER_DIAG_EN
    if (diag_hit && (mode_s1_reg != 2'd3)) begin
      blu_n = '1;
    end
`endif
    rgb_next = {blu_n, grn_n, red_n};
  end

  // ---------------- stage 2: output register ----------------
  logic [3*CHAN_BITS-1:0] rgb_reg;
  logic                   rgb_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg       <= '0;
      rgb_valid_reg <= 1'b0;
    end else begin
      rgb_valid_reg <= valid_s1_reg;
      if (valid_s1_reg) begin
        rgb_reg <= rgb_next;
      end
    end
  end

  assign bus.rgb       = rgb_reg;
  assign bus.rgb_valid = rgb_valid_reg;
  assign bus.cur_mode  = cur_mode_reg;

endmodule

// File: tb/tb_painter_modes.sv
// Bench for painter_modes: table of pattern vectors through a scoreboard, plus
// hand-written sequences for reset latency, mode switching, auto-cycling and flush.
module tb_painter_modes;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  painter_modes_if bus_m ();
  painter_modes_if bus_a ();

  painter_modes #(.INIT_MODE(2)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
  painter_modes #(.INIT_MODE(3), .AUTO_FRAMES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  int n_checks = 0;
  int n_fail   = 0;
  int n_pix    = 0;
  logic [23:0] exp_q [$];

  typedef struct packed {
    logic [1:0]  mode;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [9:0]  frame;
    logic [7:0]  sub;
    logic        diag;
    logic [23:0] rgb;
  } vec_t;

  typedef struct packed {
    logic [9:0] frame;
    logic       load;
    logic [1:0] sel;
    logic [1:0] mode;
  } auto_t;

  vec_t  tbl  [15];
  auto_t atbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: one popped expectation per valid output.
  always @(negedge clk) begin
    if (bus_m.rgb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_without_req", 32'(bus_m.rgb_valid), 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        n_pix++;
        $display("pixel %0d: rgb=%06h expected=%06h", n_pix, bus_m.rgb, e);
        check("pixel_rgb", 32'(bus_m.rgb), 32'(e));
      end
    end
  end

  task automatic set_mode(input logic [1:0] m, input logic [1:0] old);
    bus_m.mode_sel  = m ^ 2'd2;
    bus_m.mode_load = 1'b1;
    tick();
    check("load_no_fc", 32'(bus_m.cur_mode), 32'(old));
    bus_m.mode_sel = m;
    tick();
    bus_m.mode_load = 1'b0;
    tick();
    check("hold_mode", 32'(bus_m.cur_mode), 32'(old));
    bus_m.frame = bus_m.frame + 10'd1;
    tick();
    check("switch_mode", 32'(bus_m.cur_mode), 32'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]  cur_m;
    logic [23:0] e;

    //           mode   x      y      frame    sub    diag  rgb
    tbl[0]  = '{2'd2, 6'h3F, 6'h00, 10'h000, 8'h00, 1'b0, 24'h0000FC};
    tbl[1]  = '{2'd2, 6'h15, 6'h2A, 10'h1C3, 8'h00, 1'b0, 24'hC3A854};
    tbl[2]  = '{2'd2, 6'h05, 6'h05, 10'h000, 8'h00, 1'b1, 24'h001414};
    tbl[3]  = '{2'd0, 6'h08, 6'h08, 10'h000, 8'h00, 1'b1, 24'h000000};
    tbl[4]  = '{2'd0, 6'h18, 6'h0F, 10'h000, 8'h00, 1'b0, 24'h000000};
    tbl[5]  = '{2'd0, 6'h1F, 6'h08, 10'h000, 8'h00, 1'b0, 24'h0000FF};
    tbl[6]  = '{2'd0, 6'h2F, 6'h3A, 10'h00C, 8'h00, 1'b0, 24'h00FFFF};
    tbl[7]  = '{2'd0, 6'h18, 6'h0F, 10'h3F0, 8'h00, 1'b0, 24'h6D0000};
    tbl[8]  = '{2'd1, 6'h38, 6'h00, 10'h000, 8'h00, 1'b0, 24'hFFFFFF};
    tbl[9]  = '{2'd1, 6'h14, 6'h01, 10'h000, 8'h00, 1'b0, 24'h00FF00};
    tbl[10] = '{2'd1, 6'h2A, 6'h00, 10'h000, 8'h00, 1'b0, 24'hFF00FF};
    tbl[11] = '{2'd1, 6'h05, 6'h05, 10'h000, 8'h00, 1'b1, 24'h000000};
    tbl[12] = '{2'd3, 6'h00, 6'h00, 10'h000, 8'h5A, 1'b1, 24'h5A5A5A};
    tbl[13] = '{2'd3, 6'h00, 6'h00, 10'h000, 8'hFF, 1'b1, 24'hFFFFFF};
    tbl[14] = '{2'd3, 6'h07, 6'h07, 10'h000, 8'h01, 1'b1, 24'h010101};

    //           frame    load  sel   mode-after
    atbl[0]  = '{10'd1, 1'b0, 2'd0, 2'd3};
    atbl[1]  = '{10'd1, 1'b0, 2'd0, 2'd3};
    atbl[2]  = '{10'd2, 1'b0, 2'd0, 2'd0};
    atbl[3]  = '{10'd3, 1'b0, 2'd0, 2'd0};
    atbl[4]  = '{10'd4, 1'b0, 2'd0, 2'd1};
    atbl[5]  = '{10'd4, 1'b0, 2'd0, 2'd1};
    atbl[6]  = '{10'd5, 1'b0, 2'd0, 2'd1};
    atbl[7]  = '{10'd6, 1'b1, 2'd3, 2'd2};
    atbl[8]  = '{10'd7, 1'b0, 2'd0, 2'd3};
    atbl[9]  = '{10'd8, 1'b0, 2'd0, 2'd3};
    atbl[10] = '{10'd9, 1'b0, 2'd0, 2'd0};

    bus_m.frame = '0; bus_m.subframe = '0; bus_m.x = '0; bus_m.y = '0;
    bus_m.req = 1'b0; bus_m.mode_sel = '0; bus_m.mode_load = 1'b0;
    bus_a.frame = '0; bus_a.subframe = '0; bus_a.x = '0; bus_a.y = '0;
    bus_a.req = 1'b0; bus_a.mode_sel = '0; bus_a.mode_load = 1'b0;

    // Reset with requests streaming: they must be flushed, then 2-cycle latency.
    reset = 1'b1;
    bus_m.req = 1'b1;
    bus_m.x = 6'h3F;
    repeat (3) tick();
    check("reset_valid", 32'(bus_m.rgb_valid), 32'd0);
    check("reset_rgb", 32'(bus_m.rgb), 32'd0);
    check("reset_mode", 32'(bus_m.cur_mode), 32'd2);
    check("reset_mode_auto", 32'(bus_a.cur_mode), 32'd3);
    reset = 1'b0;
    exp_q.push_back(24'h0000FC);
    tick();
    check("lat1_valid", 32'(bus_m.rgb_valid), 32'd0);
    check("lat1_mode", 32'(bus_m.cur_mode), 32'd2);
    exp_q.push_back(24'h0000FC);
    tick();
    check("lat2_valid", 32'(bus_m.rgb_valid), 32'd1);
    check("lat2_rgb", 32'(bus_m.rgb), 32'h0000FC);
    bus_m.req = 1'b0;
    tick();
    tick();
    check("idle_valid", 32'(bus_m.rgb_valid), 32'd0);
    check("hold_rgb", 32'(bus_m.rgb), 32'h0000FC);

    // Pattern vectors, back-to-back within each mode group.
    cur_m = 2'd2;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].mode != cur_m) begin
        bus_m.req = 1'b0;
        set_mode(tbl[i].mode, cur_m);
        cur_m = tbl[i].mode;
      end
      bus_m.req      = 1'b1;
      bus_m.x        = tbl[i].x;
      bus_m.y        = tbl[i].y;
      bus_m.frame    = tbl[i].frame;
      bus_m.subframe = tbl[i].sub;
      e = tbl[i].rgb;
`ifdef PAINTER_DIAG_EN
      if (tbl[i].diag && tbl[i].mode != 2'd3) e[23:16] = 8'hFF;
`endif
      exp_q.push_back(e);
      tick();
    end
    bus_m.req = 1'b0;
    tick();

    // Load coinciding with a frame change: old pending applies, new one waits.
    bus_m.mode_sel = 2'd1; bus_m.mode_load = 1'b1;
    tick();
    bus_m.mode_load = 1'b0;
    tick();
    check("pend_steady", 32'(bus_m.cur_mode), 32'd3);
    bus_m.frame = bus_m.frame + 10'd1;
    bus_m.mode_sel = 2'd2; bus_m.mode_load = 1'b1;
    tick();
    bus_m.mode_load = 1'b0;
    check("fc_load_old", 32'(bus_m.cur_mode), 32'd1);
    tick();
    check("fc_load_hold", 32'(bus_m.cur_mode), 32'd1);
    bus_m.frame = bus_m.frame + 10'd1;
    tick();
    check("fc_load_new", 32'(bus_m.cur_mode), 32'd2);
    bus_m.frame = bus_m.frame + 10'd1;
    tick();
    check("no_pending", 32'(bus_m.cur_mode), 32'd2);

    // Auto-cycling instance.
    for (int i = 0; i < 11; i++) begin
      bus_a.frame     = atbl[i].frame;
      bus_a.mode_load = atbl[i].load;
      bus_a.mode_sel  = atbl[i].sel;
      tick();
      bus_a.mode_load = 1'b0;
      $display("auto step %0d: frame=%0d cur_mode=%0d expected=%0d",
               i, atbl[i].frame, bus_a.cur_mode, atbl[i].mode);
      check("auto_mode", 32'(bus_a.cur_mode), 32'(atbl[i].mode));
    end

    // Reset mid-stream: the in-flight request must never produce a valid.
    bus_m.req = 1'b1;
    tick();
    bus_m.req = 1'b0;
    reset = 1'b1;
    tick();
    check("flush_valid", 32'(bus_m.rgb_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_flush_valid", 32'(bus_m.rgb_valid), 32'd0);
    end
    check("post_flush_rgb", 32'(bus_m.rgb), 32'd0);
    check("post_flush_mode", 32'(bus_m.cur_mode), 32'd2);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
